instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 146 ++++++++++++++
 tb/tb_instr_encoder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder.
// Packs the fields of one instruction into a 32-bit word for each accepted input.
// Each output word is paired with its sequential word address.
// A session starts on a start pulse and covers len instructions.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// Valid and its payload stay stable until ready is seen. Ready may depend
// combinationally on the downstream ready.
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] len,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  fmt,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        out_err,
    output logic        busy,
    output logic        done,
    output logic [7:0]  err_cnt,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] len_q;
    logic [15:0] idx;
    logic [31:0] addr_q;
    logic        accept;
    logic        out_fire;
    logic        last;
    logic [31:0] enc_instr;
    logic        enc_err;

    // The output register is a single entry, so new input is taken whenever it empties this cycle.
    assign in_ready  = (state == RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last      = (idx == len_q - 16'd1);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign dbg_state = state;

    // Encode the current input fields and flag out-of-range or unencodable immediates.
    always_comb begin
        enc_instr = 32'h0000_0013;
        enc_err   = 1'b0;
        case (fmt)
            3'd0: enc_instr = {funct7, rs2, rs1, funct3, rd, op};
            3'd1: begin
                enc_instr = {imm[11:0], rs1, funct3, rd, op};
                enc_err   = ($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047);
            end
            3'd2: begin
                enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], op};
                enc_err   = ($signed(imm) < -32'sd2048) || ($signed(imm) > 32'sd2047);
            end
            3'd3: begin
                enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                enc_err   = ($signed(imm) < -32'sd4096) || ($signed(imm) > 32'sd4094) || imm[0];
            end
            3'd4: begin
                enc_instr = {imm[31:12], rd, op};
                enc_err   = (imm[11:0] != 12'd0);
            end
            3'd5: begin
                enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                enc_err   = ($signed(imm) < -32'sd1048576) || ($signed(imm) > 32'sd1048574) || imm[0];
            end
            default: begin
                enc_instr = 32'h0000_0013;
                enc_err   = 1'b1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Session sequencing: start, accept len inputs, drain the last word, pulse done.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len == 16'd0) ? DONE : RUN;
            RUN:     if (accept && last) state_nxt = DRAIN;
            DRAIN:   if (out_fire) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Session parameters, output register, address counter and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q     <= 16'd0;
            idx       <= 16'd0;
            addr_q    <= 32'd0;
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_addr  <= 32'd0;
            out_err   <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            if (state == IDLE && start) begin
                len_q   <= len;
                idx     <= 16'd0;
                addr_q  <= {base_addr[31:2], 2'b00};
                err_cnt <= 8'd0;
            end
            if (accept) begin
                out_valid <= 1'b1;
                out_instr <= enc_instr;
                out_addr  <= addr_q;
                out_err   <= enc_err;
                addr_q    <= addr_q + 32'd4;
                idx       <= idx + 16'd1;
                if (enc_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed sessions plus randomized sessions
// scored against a reference model that packs fields with shifts and checks ranges
// with integer comparisons.
module tb_instr_encoder;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        has_exp;
        logic [31:0] exp_instr;
    } in_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic [31:0] base_addr;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        busy;
    logic        done;
    logic [7:0]  err_cnt;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    in_t         stim_q[$];
    logic [64:0] exp_q[$];   // {err, addr, instr}

    int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578};

    instr_encoder dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .op(op),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_addr(out_addr), .out_err(out_err), .busy(busy), .done(done),
        .err_cnt(err_cnt), .dbg_state(dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: returns {err, instr}.
    function automatic logic [32:0] ref_encode(input in_t s);
        logic [31:0] im, o, f3, f7, rd_, r1, r2, w;
        int          iv;
        logic        e;
        im = s.imm; iv = int'(signed'(s.imm));
        o = 32'(s.op); f3 = 32'(s.f3); f7 = 32'(s.f7);
        rd_ = 32'(s.rd); r1 = 32'(s.rs1); r2 = 32'(s.rs2);
        e = 1'b0;
        case (s.fmt)
            3'd0: w = (f7 << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (rd_ << 7) | o;
            3'd1: begin
                w = ((im & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (rd_ << 7) | o;
                e = (iv < -2048) || (iv > 2047);
            end
            3'd2: begin
                w = (((im >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12)
                    | ((im & 32'h1F) << 7) | o;
                e = (iv < -2048) || (iv > 2047);
            end
            3'd3: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (r2 << 20)
                    | (r1 << 15) | (f3 << 12) | (((im >> 1) & 32'hF) << 8)
                    | (((im >> 11) & 32'h1) << 7) | o;
                e = (iv < -4096) || (iv > 4094) || ((im & 32'h1) != 0);
            end
            3'd4: begin
                w = (im & 32'hFFFF_F000) | (rd_ << 7) | o;
                e = ((im & 32'hFFF) != 0);
            end
            3'd5: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                    | (rd_ << 7) | o;
                e = (iv < -1048576) || (iv > 1048574) || ((im & 32'h1) != 0);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
        return {e, w};
    endfunction

    function automatic in_t mk(input logic [2:0] f, input logic [6:0] o, input logic [2:0] f3,
                               input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                               input logic [31:0] i, input logic [31:0] ex);
        in_t s;
        s.fmt = f; s.op = o; s.f3 = f3; s.f7 = 7'd0; s.rd = d; s.rs1 = s1; s.rs2 = s2;
        s.imm = i; s.has_exp = 1'b1; s.exp_instr = ex;
        return s;
    endfunction

    function automatic in_t rand_stim(input bit only_err);
        in_t s;
        s.fmt = only_err ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
        s.op = 7'($urandom); s.f3 = 3'($urandom); s.f7 = 7'($urandom);
        s.rd = 5'($urandom); s.rs1 = 5'($urandom); s.rs2 = 5'($urandom);
        s.has_exp = 1'b0; s.exp_instr = 32'd0;
        case ($urandom_range(0, 4))
            0:       s.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            1:       s.imm = $urandom;
            2:       s.imm = 32'(bnd[$urandom_range(0, 11)]);
            3:       s.imm = $urandom & 32'hFFFF_F000;
            default: s.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
        endcase
        return s;
    endfunction

    // Driver: present the head of the stimulus queue and randomize flow control.
    task automatic drive(input int vprob, input int rprob, input bit hold_rdy);
        in_valid = (stim_q.size() > 0) && ($urandom_range(1, 100) <= vprob);
        if (stim_q.size() > 0) begin
            fmt = stim_q[0].fmt; op = stim_q[0].op; funct3 = stim_q[0].f3;
            funct7 = stim_q[0].f7; rd = stim_q[0].rd; rs1 = stim_q[0].rs1;
            rs2 = stim_q[0].rs2; imm = stim_q[0].imm;
        end
        out_ready = hold_rdy ? 1'b0 : ($urandom_range(1, 100) <= rprob);
        start     = busy && ($urandom_range(0, 7) == 0);
        len       = 16'($urandom);
        base_addr = $urandom;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        stim_q.delete(); exp_q.delete();
    endtask

    // One session: start, drive all queued stimulus, score every output, wait for done.
    task automatic run_session(input logic [15:0] l, input logic [31:0] b,
                               input int vprob, input int rprob, input int hold);
        logic [31:0] addr_m;
        logic [7:0]  ecnt_m;
        logic [32:0] r;
        logic [64:0] e;
        logic [31:0] prev_instr, prev_addr;
        int acc, pops, cyc, hold_left;
        bit seen_done;
        addr_m = b & ~32'd3; ecnt_m = 8'd0;
        acc = 0; pops = 0; cyc = 0; hold_left = hold; seen_done = 1'b0;
        prev_instr = 32'd0; prev_addr = 32'd0;
        @(posedge clk); #1;
        start = 1'b1; len = l; base_addr = b; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        drive(vprob, rprob, hold_left > 0);
        start = 1'b0;
        while (!seen_done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen_done = 1'b1;
                start = 1'b0; in_valid = 1'b0;
                check("done_empty", 32'(exp_q.size()), 32'd0);
                check("done_count", 32'(acc), 32'(l));
                check("done_errcnt", 32'(err_cnt), 32'(ecnt_m));
                check("done_ovalid", 32'(out_valid), 32'd0);
                if (l == 16'd0) check("len0_latency", 32'(cyc), 32'd1);
            end else begin
                if (hold > 0 && hold_left == 0 && pops < int'(l))
                    check("thruput_ovalid", 32'(out_valid), 32'd1);
                if (hold_left > 0 && out_valid) begin
                    if (hold_left < hold) begin
                        check("bp_instr_stable", out_instr, prev_instr);
                        check("bp_addr_stable", out_addr, prev_addr);
                    end
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    prev_instr = out_instr; prev_addr = out_addr;
                    hold_left--;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_instr", out_instr, e[31:0]);
                        check("out_addr", out_addr, e[63:32]);
                        check("out_err", 32'(out_err), 32'(e[64]));
                    end
                    pops++;
                end
                if (in_valid && in_ready) begin
                    r = ref_encode(stim_q[0]);
                    if (stim_q[0].has_exp) r[31:0] = stim_q[0].exp_instr;
                    exp_q.push_back({r[32], addr_m, r[31:0]});
                    addr_m = addr_m + 32'd4;
                    if (r[32] && ecnt_m != 8'hFF) ecnt_m = ecnt_m + 8'd1;
                    void'(stim_q.pop_front());
                    acc++;
                end
                @(posedge clk); #1;
                drive(vprob, rprob, hold_left > 0);
            end
        end
        if (!seen_done) check("done_timeout", 32'd0, 32'd1);
        stim_q.delete(); exp_q.delete();
        @(negedge clk);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; len = 16'd0; base_addr = 32'd0;
        in_valid = 1'b0; out_ready = 1'b0; fmt = 3'd0; op = 7'd0; funct3 = 3'd0;
        funct7 = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd0;

        // Reset state (start and handshakes held high during reset)
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_out_addr", out_addr, 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Known encodings
        stim_q.push_back(mk(3'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093));
        stim_q.push_back(mk(3'd2, 7'h23, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423));
        stim_q.push_back(mk(3'd3, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3));
        stim_q.push_back(mk(3'd5, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h0010_00EF));
        run_session(16'd4, 32'h100, 100, 100, 0);

        // Backpressure for 3 cycles, then continuous flow
        for (int i = 0; i < 4; i++) stim_q.push_back(rand_stim(1'b0));
        run_session(16'd4, $urandom, 100, 100, 3);

        // Error cases
        stim_q.push_back(mk(3'd1, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 32'h8000_0093));
        stim_q.push_back(mk(3'd3, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3, 32'h0000_0163));
        stim_q.push_back(mk(3'd7, 7'h33, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'h0000_0013));
        run_session(16'd3, 32'h2000, 100, 100, 0);
        check("err_cnt_three", 32'(err_cnt), 32'd3);

        // Empty session and address wrap
        run_session(16'd0, 32'h40, 100, 100, 0);
        for (int i = 0; i < 2; i++) stim_q.push_back(rand_stim(1'b0));
        run_session(16'd2, 32'hFFFF_FFFC, 100, 100, 0);

        // Reset while draining with a held output
        stim_q.push_back(rand_stim(1'b0));
        @(posedge clk); #1;
        start = 1'b1; len = 16'd1; base_addr = 32'h300; out_ready = 1'b0;
        drive(100, 0, 1'b1);
        start = 1'b1; len = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_state_drain", 32'(dbg_state), 32'd2);
        check("mid_out_valid", 32'(out_valid), 32'd1);
        reset = 1'b1; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        stim_q.delete(); exp_q.delete();
        @(negedge clk);
        check("mid_rst_ovalid", 32'(out_valid), 32'd0);
        check("mid_rst_instr", out_instr, 32'd0);
        check("mid_rst_addr", out_addr, 32'd0);
        check("mid_rst_err", 32'(out_err), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_errcnt", 32'(err_cnt), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);

        // Randomized sessions with random flow control
        for (int k = 0; k < 10; k++) begin
            int n;
            n = $urandom_range(1, 24);
            for (int i = 0; i < n; i++) stim_q.push_back(rand_stim(1'b0));
            run_session(16'(n), $urandom, $urandom_range(30, 100), $urandom_range(30, 100), 0);
        end

        // Error counter saturation
        for (int i = 0; i < 300; i++) stim_q.push_back(rand_stim(1'b1));
        run_session(16'd300, $urandom, 100, 100, 0);
        check("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
